// File: rtl/sar_adc_ctrl.sv
// Successive-approximation conversion controller.
// A rising edge on start runs track/hold for SAMPLE_CYCLES clocks, then an N-bit
// binary search (one trial per clock) driving dac_code and reading comp. The
// result is published on data and flagged by an EOC_WIDTH-clock eoc pulse.
module sar_adc_ctrl #(
    parameter int unsigned N             = 8,
    parameter int unsigned SAMPLE_CYCLES = 2,
    parameter int unsigned EOC_WIDTH     = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         comp,
    output logic         sample,
    output logic [N-1:0] dac_code,
    output logic         busy,
    output logic         eoc,
    output logic [N-1:0] data
);

    // One counter serves both the sample phase and the eoc phase.
    localparam int unsigned CntMax = (SAMPLE_CYCLES > EOC_WIDTH) ? SAMPLE_CYCLES : EOC_WIDTH;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam int unsigned IdxW   = $clog2(N);

    localparam logic [CntW-1:0] SampleLast = CntW'(SAMPLE_CYCLES - 1);
    localparam logic [CntW-1:0] EocLast    = CntW'(EOC_WIDTH - 1);
    localparam logic [IdxW-1:0] IdxTop     = IdxW'(N - 1);
    localparam logic [N-1:0]    MsbCode    = N'(1) << (N - 1);

    typedef enum logic [1:0] {StIdle, StSample, StConvert, StDone} state_e;

    state_e          r_state;
    logic            r_start_q;
    logic            r_sample;
    logic [N-1:0]    r_dac;
    logic            r_busy;
    logic            r_eoc;
    logic [N-1:0]    r_data;
    logic [CntW-1:0] r_cnt;
    logic [IdxW-1:0] r_idx;
    logic [N-1:0]    r_result;

    logic            w_start_edge;
    logic [N-1:0]    w_bit;
    logic [N-1:0]    w_res;

    assign w_start_edge = start & ~r_start_q;
    // Bit under trial, and the result with that bit resolved from the comparator.
    assign w_bit        = N'(1) << r_idx;
    assign w_res        = comp ? (r_result | w_bit) : r_result;

    assign sample   = r_sample;
    assign dac_code = r_dac;
    assign busy     = r_busy;
    assign eoc      = r_eoc;
    assign data     = r_data;

    // Previous start level for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start_q <= 1'b0;
        end else begin
            r_start_q <= start;
        end
    end

    // Conversion FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_sample <= 1'b0;
            r_dac    <= '0;
            r_busy   <= 1'b0;
            r_eoc    <= 1'b0;
            r_data   <= '0;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_result <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_start_edge) begin
                        r_state  <= StSample;
                        r_sample <= 1'b1;
                        r_busy   <= 1'b1;
                        r_cnt    <= '0;
                    end
                end
                StSample: begin
                    r_cnt <= r_cnt + CntW'(1);
                    if (r_cnt == SampleLast) begin
                        r_state  <= StConvert;
                        r_sample <= 1'b0;
                        r_idx    <= IdxTop;
                        r_dac    <= MsbCode;
                        r_result <= '0;
                    end
                end
                StConvert: begin
                    r_result <= w_res;
                    if (r_idx != '0) begin
                        // Keep resolved bits, try the next lower bit.
                        r_dac <= w_res | (w_bit >> 1);
                        r_idx <= r_idx - IdxW'(1);
                    end else begin
                        r_data  <= w_res;
                        r_dac   <= w_res;
                        r_eoc   <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    r_cnt <= r_cnt + CntW'(1);
                    if (r_cnt == EocLast) begin
                        r_eoc   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= StIdle;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule
